// File: rtl/lcd_spi_master_if.sv
// rtl/lcd_spi_master_if.sv - command word handshake between the FIFO drain logic and lcd_spi_master
interface lcd_spi_master_if;
    logic       valid;
    logic       ready;
    logic [7:0] cmd;
    logic       mode;

    modport master (output valid, output cmd, output mode, input ready);
    modport slave  (input valid, input cmd, input mode, output ready);
endinterface

// File: rtl/lcd_spi_master.sv
// rtl/lcd_spi_master.sv - mode-0 SPI byte serializer for the LCD; LCD_SPI_BURST_EN keeps chip select low across back-to-back bytes
module lcd_spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    lcd_spi_master_if.slave cmd_if,
    output logic            sdcard_csn,
    output logic            flash_csn,
    output logic            lcd_csn,
    output logic            sck,
    output logic            mosi,
    output logic            lcd_dc
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT_LO, S_SHIFT_HI, S_HOLD, S_GAP
    } state_t;

    localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);
`ifdef LCD_SPI_BURST_EN
    localparam logic BURST = 1'b1;
`else
    localparam logic BURST = 1'b0;
`endif

    state_t     state, state_d;
    logic [7:0] phase_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       dc_q;
    logic       pending, pending_d;
    logic       ready_q, ready_d;
    logic       phase_done, accept;
    logic       csn_d, sck_d, mosi_d, dc_d;

    assign phase_done   = (phase_cnt == PH_LAST);
    assign accept       = cmd_if.valid & ready_q;
    assign cmd_if.ready = ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            dc_q      <= 1'b0;
            pending   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state   <= state_d;
            pending <= pending_d;
            ready_q <= ready_d;
            if (state_d != state || state == S_IDLE)
                phase_cnt <= '0;
            else
                phase_cnt <= phase_cnt + 8'd1;
            // Accept only happens in IDLE or HOLD, so it never collides with a shift.
            if (accept) begin
                shreg   <= cmd_if.cmd;
                dc_q    <= cmd_if.mode;
                bit_cnt <= 3'd7;
            end else if (state == S_SHIFT_HI && phase_done && bit_cnt != 3'd0) begin
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt - 3'd1;
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:     if (accept)     state_d = S_SETUP;
            S_SETUP:    if (phase_done) state_d = S_SHIFT_LO;
            S_SHIFT_LO: if (phase_done) state_d = S_SHIFT_HI;
            S_SHIFT_HI: if (phase_done) state_d = (bit_cnt == 3'd0) ? S_HOLD : S_SHIFT_LO;
            S_HOLD:     if (phase_done) state_d = (pending | accept) ? S_SETUP : S_GAP;
            S_GAP:      if (phase_done) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
        pending_d = (state_d == S_HOLD) ? (pending | accept) : 1'b0;
        ready_d   = (state_d == S_IDLE) | (BURST & (state_d == S_HOLD) & ~pending_d);
    end

    // Chip select rises one cycle into GAP so the inter-frame high time is exactly CLK_DIV.
    always_comb begin
        sck_d  = (state == S_SHIFT_HI);
        csn_d  = (state == S_IDLE) | ((state == S_GAP) & (phase_cnt != 8'd0));
        mosi_d = mosi;
        dc_d   = lcd_dc;
        case (state)
            S_SETUP, S_SHIFT_LO, S_SHIFT_HI: begin
                mosi_d = shreg[7];
                dc_d   = dc_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_csn    <= 1'b1;
            sck        <= 1'b0;
            mosi       <= 1'b0;
            lcd_dc     <= 1'b0;
            sdcard_csn <= 1'b1;
            flash_csn  <= 1'b1;
        end else begin
            lcd_csn    <= csn_d;
            sck        <= sck_d;
            mosi       <= mosi_d;
            lcd_dc     <= dc_d;
            sdcard_csn <= 1'b1;
            flash_csn  <= 1'b1;
        end
    end
endmodule
